pes_icg_ctrl: RTL and testbench

//  Clock-gate enable controller: drives the enable of a pes_icg integrated clock-gating cell.

---
 rtl/pes_icg_ctrl.sv | 74 +++++++
 tb/tb_pes_icg_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pes_icg_ctrl.sv
// pes_icg_ctrl: idle-timeout enable controller for a pes_icg clock-gating cell with wake handshake.
// Define PES_ICG_STATS_EN to count cycles spent gated on gated_cnt; otherwise gated_cnt is tied to 0.
module pes_icg_ctrl #(
   parameter int NUM_REQ     = 2,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 4,
   parameter int STAT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] act_req,
   input  logic               force_on,
   output logic               gate_en,
   output logic               wake_ack,
   output logic [1:0]         state,
   output logic [STAT_W-1:0]  gated_cnt
);
   typedef enum logic [1:0] {RUN, IDLE_WAIT, GATED, WAKE} state_t;
   localparam logic [CNT_W-1:0] IDLE_N = CNT_W'(IDLE_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_N = CNT_W'(WAKE_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   if (NUM_REQ < 1 || IDLE_CYCLES < 1 || WAKE_CYCLES < 1 ||
       (64'(1) << CNT_W) - 1 < 64'(IDLE_CYCLES) || (64'(1) << CNT_W) - 1 < 64'(WAKE_CYCLES)) begin : g_param_err
      $error("pes_icg_ctrl: illegal parameters (CNT_W too narrow or count below 1)");
   end
   state_t st;
   logic [CNT_W-1:0] cnt;
   logic act;
   assign act   = |act_req | force_on;
   assign state = st;
   // gate_en is only ever updated here, on posedge clk, keeping it stable while clk is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= RUN;
         gate_en  <= 1'b1;
         wake_ack <= 1'b0;
         cnt      <= '0;
      end else begin
         wake_ack <= 1'b0;
         case (st)
            RUN: if (!act) begin
               st  <= IDLE_WAIT;
               cnt <= ONE;
            end
            IDLE_WAIT: if (act) begin
               st  <= RUN;
               cnt <= '0;
            end else if (cnt == IDLE_N) begin
               st      <= GATED;
               gate_en <= 1'b0;
            end else if (cnt != '1) cnt <= cnt + ONE;
            GATED: if (act) begin
               st      <= WAKE;
               cnt     <= ONE;
               gate_en <= 1'b1;
            end
            WAKE: if (cnt == WAKE_N) begin
               st       <= RUN;
               wake_ack <= 1'b1;
               cnt      <= '0;
            end else if (cnt != '1) cnt <= cnt + ONE;
         endcase
      end
   end
`ifdef PES_ICG_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) gated_cnt <= '0;
      else if (st == GATED && gated_cnt != '1) gated_cnt <= gated_cnt + STAT_W'(1);
   end
`else
   assign gated_cnt = '0;
`endif
endmodule

// File: tb/tb_pes_icg_ctrl.sv
// tb_pes_icg_ctrl: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_pes_icg_ctrl;
   localparam int IDLE = 4;
   localparam int WAKE = 2;
`ifdef PES_ICG_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif
   logic clk, rst, force_on, gate_en, wake_ack;
   logic [1:0] act_req, state;
   logic [15:0] gated_cnt;
   int n_cmp = 0, n_err = 0;

   pes_icg_ctrl #(.NUM_REQ(2), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .act_req(act_req), .force_on(force_on),
      .gate_en(gate_en), .wake_ack(wake_ack), .state(state), .gated_cnt(gated_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: count consecutive idle samples, a gated flag, and remaining wake cycles
   bit m_gated, m_ack;
   int m_idle, m_wake, m_stat;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_gated = 0; m_ack = 0; m_idle = 0; m_wake = 0; m_stat = 0;
      end else begin
         m_ack = 0;
         if (STATS != 0 && m_gated && m_wake == 0 && m_stat < 65535) m_stat++;
         if (m_wake > 0) begin
            m_wake--;
            if (m_wake == 0) m_ack = 1;
         end else if (m_gated) begin
            if (act_req != 0 || force_on) begin
               m_gated = 0;
               m_wake = WAKE;
            end
         end else begin
            m_idle = (act_req != 0 || force_on) ? 0 : m_idle + 1;
            if (m_idle == IDLE + 1) begin
               m_gated = 1;
               m_idle = 0;
            end
         end
      end
   end

   always @(negedge clk) if (!rst) begin
      chk("model_state", int'(state), m_wake > 0 ? 3 : m_gated ? 2 : m_idle > 0 ? 1 : 0);
      chk("model_gate_en", int'(gate_en), (!m_gated || m_wake > 0) ? 1 : 0);
      chk("model_wake_ack", int'(wake_ack), int'(m_ack));
      chk("model_gated_cnt", int'(gated_cnt), m_stat);
   end

   initial begin
      rst = 1; act_req = 0; force_on = 0;
      repeat (2) @(negedge clk);
      chk("rst_gate_en", int'(gate_en), 1);
      chk("rst_state", int'(state), 0);
      chk("rst_wake_ack", int'(wake_ack), 0);
      chk("rst_gated_cnt", int'(gated_cnt), 0);
      rst = 0;
      @(negedge clk);
      chk("idle_enter_state", int'(state), 1);
      repeat (3) @(negedge clk);
      chk("idle_hold_gate_en", int'(gate_en), 1);
      @(negedge clk);
      chk("idle_gate_en_low", int'(gate_en), 0);
      chk("idle_gated_state", int'(state), 2);
      repeat (10) @(negedge clk);
      chk("stats_10", int'(gated_cnt), STATS != 0 ? 10 : 0);
      act_req = 2'b10;
      @(negedge clk);
      chk("wake_gate_en", int'(gate_en), 1);
      chk("wake_state1", int'(state), 3);
      act_req = 0;
      @(negedge clk);
      chk("wake_state2", int'(state), 3);
      chk("wake_ack_early", int'(wake_ack), 0);
      @(negedge clk);
      chk("wake_done_state", int'(state), 0);
      chk("wake_ack_pulse", int'(wake_ack), 1);
      act_req = 2'b01;
      @(negedge clk);
      chk("wake_ack_clear", int'(wake_ack), 0);
      act_req = 0;
      repeat (3) @(negedge clk);
      chk("abort_waiting", int'(state), 1);
      act_req = 2'b01;
      @(negedge clk);
      chk("abort_state", int'(state), 0);
      chk("abort_gate_en", int'(gate_en), 1);
      act_req = 0;
      repeat (4) @(negedge clk);
      chk("expiry_waiting", int'(state), 1);
      act_req = 2'b10;
      @(negedge clk);
      chk("expiry_act_state", int'(state), 0);
      chk("expiry_act_gate_en", int'(gate_en), 1);
      force_on = 1; act_req = 0;
      repeat (20) @(negedge clk);
      chk("force_state", int'(state), 0);
      chk("force_gate_en", int'(gate_en), 1);
      force_on = 0;
      repeat (5) @(negedge clk);
      chk("regate_state", int'(state), 2);
      act_req = 2'b11;
      repeat (3) @(negedge clk);
      chk("held_wake_ack", int'(wake_ack), 1);
      act_req = 0;
      repeat (6) @(negedge clk);
      chk("pre_rst_gated", int'(state), 2);
      #1 rst = 1;
      #1;
      chk("async_rst_gate_en", int'(gate_en), 1);
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_wake_ack", int'(wake_ack), 0);
      chk("async_rst_gated_cnt", int'(gated_cnt), 0);
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
